// File: rtl/pad_blk_pkg.sv
// Shared constants and state encoding for the SHA3-256 padding block.
// Lane indices count 0..24 within one 25-lane Keccak block.
package pad_blk_pkg;

  localparam int RATE_LANES = 17;
  localparam int NUM_LANES  = 25;
  localparam int LANE_W     = 5;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_END    = 8'h80;

  localparam logic [LANE_W-1:0] LAST_RATE_LANE = LANE_W'(RATE_LANES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE      = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ABSORB,
    PADFILL,
    CAP
  } state_t;

endpackage

// File: rtl/pad_blk_if.sv
// Word-in / lane-out handshake bundle for pad_blk.
// The slave view is the padder itself; the master view drives it.
interface pad_blk_if;

  logic        pushin;
  logic        stopin;
  logic        firstin;
  logic        lastin;
  logic [3:0]  nbytes;
  logic [63:0] din;
  logic        pushout;
  logic        stopout;
  logic        firstout;
  logic [63:0] dout;

  modport slave (
    input  pushin, firstin, lastin, nbytes, din, stopout,
    output stopin, pushout, firstout, dout
  );

  modport master (
    output pushin, firstin, lastin, nbytes, din, stopout,
    input  stopin, pushout, firstout, dout
  );

endinterface

// File: rtl/pad_lane.sv
// Combinational byte masking and SHA3 pad insertion for one 64-bit lane.
// A short final word gets 0x06 after its last byte; a deferred pad lands in byte 0.
module pad_lane
  import pad_blk_pkg::*;
(
  input  logic [63:0]       i_din,
  input  logic [3:0]        i_nbytes,
  input  logic              i_lastin,
  input  logic [LANE_W-1:0] i_lane,
  input  logic              i_padPending,
  output logic [63:0]       o_lane
);

  logic w_short;

  assign w_short = i_lastin && (i_nbytes < 4'd8);

  always_comb begin
    o_lane = i_din;
    for (int i = 0; i < 8; i++) begin
      if (w_short && (4'(i) >= i_nbytes)) o_lane[8*i +: 8] = 8'h00;
      if (w_short && (4'(i) == i_nbytes)) o_lane[8*i +: 8] = PAD_DOMAIN;
    end
    // Final rate lane also carries the closing pad bit (0x86 when n=7).
    if (w_short && (i_lane == LAST_RATE_LANE)) o_lane[63:56] = o_lane[63:56] | PAD_END;
    if (i_padPending) o_lane[7:0] = o_lane[7:0] | PAD_DOMAIN;
  end

endmodule

// File: rtl/pad_blk.sv
// SHA3-256 padder: turns a byte-counted word stream into 25-lane Keccak blocks
// (17 rate lanes, 8 zero capacity lanes) through a single registered output stage.
module pad_blk
  import pad_blk_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  pad_blk_if.slave  bus
);

  state_t            r_state;
  logic [LANE_W-1:0] r_lane;
  logic              r_padPending;
  logic              r_endMsg;
  logic              r_pushout;
  logic              r_firstout;
  logic [63:0]       r_dout;

  logic              w_fill;
  logic              w_adv;
  logic              w_stopin;
  logic              w_xfer;
  logic              w_take;
  logic              w_fullLast;
  logic [63:0]       w_padded;
  logic [63:0]       w_nextLane;

  assign w_fill     = (r_state == PADFILL);
  assign w_adv      = !(r_pushout && bus.stopout);
  assign w_stopin   = (r_state == PADFILL) || (r_state == CAP) || !w_adv;
  assign w_xfer     = bus.pushin && !w_stopin;
  assign w_take     = w_xfer && ((r_state == ABSORB) || bus.firstin);
  assign w_fullLast = bus.lastin && (bus.nbytes >= 4'd8);

  pad_lane u_padLane (
    .i_din        (w_fill ? 64'd0 : bus.din),
    .i_nbytes     (bus.nbytes),
    .i_lastin     (!w_fill && bus.lastin),
    .i_lane       (r_lane),
    .i_padPending (r_padPending),
    .o_lane       (w_padded)
  );

  // Fill lanes never see a short final word, so the closing bit is added here.
  assign w_nextLane = w_padded |
                      ((w_fill && (r_lane == LAST_RATE_LANE)) ? {PAD_END, 56'd0} : 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lane       <= '0;
      r_padPending <= 1'b0;
      r_endMsg     <= 1'b0;
      r_pushout    <= 1'b0;
      r_firstout   <= 1'b0;
      r_dout       <= 64'd0;
    end else if (w_adv) begin
      r_pushout  <= 1'b0;
      r_firstout <= 1'b0;
      case (r_state)
        IDLE, ABSORB: begin
          if (w_take) begin
            r_dout     <= w_nextLane;
            r_pushout  <= 1'b1;
            r_firstout <= (r_lane == '0);
            r_lane     <= r_lane + 1'b1;
            if (bus.lastin) begin
              r_endMsg     <= 1'b1;
              r_padPending <= w_fullLast;
              r_state      <= (r_lane == LAST_RATE_LANE) ? CAP : PADFILL;
            end else begin
              r_state <= (r_lane == LAST_RATE_LANE) ? CAP : ABSORB;
            end
          end
        end
        PADFILL: begin
          r_dout       <= w_nextLane;
          r_pushout    <= 1'b1;
          r_firstout   <= (r_lane == '0);
          r_padPending <= 1'b0;
          r_lane       <= r_lane + 1'b1;
          if (r_lane == LAST_RATE_LANE) r_state <= CAP;
        end
        CAP: begin
          r_dout    <= 64'd0;
          r_pushout <= 1'b1;
          // A deferred pad after a full final lane 16 needs a whole extra block.
          if (r_lane == LAST_LANE) begin
            r_lane <= '0;
            if (r_padPending) begin
              r_state <= PADFILL;
            end else if (r_endMsg) begin
              r_endMsg <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_state <= ABSORB;
            end
          end else begin
            r_lane <= r_lane + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stopin   = w_stopin;
  assign bus.pushout  = r_pushout;
  assign bus.firstout = r_firstout;
  assign bus.dout     = r_dout;

endmodule

// File: tb/tb_pad_blk.sv
// Directed self-checking bench for pad_blk: lanes are collected as they transfer
// and compared against hand-derived SHA3-256 padded blocks.
module tb_pad_blk;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] lanes[$];
  logic        firsts[$];

  pad_blk_if bus ();

  pad_blk dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Record every lane that will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.pushout && !bus.stopout) begin
      lanes.push_back(bus.dout);
      firsts.push_back(bus.firstout);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [63:0] d, input logic f, input logic l, input logic [3:0] n);
    int cyc;
    cyc = 0;
    bus.pushin  = 1'b1;
    bus.din     = d;
    bus.firstin = f;
    bus.lastin  = l;
    bus.nbytes  = n;
    @(negedge clk);
    while (bus.stopin && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
    bus.lastin  = 1'b0;
    bus.nbytes  = 4'd0;
  endtask

  task automatic waitLanes(input int n);
    int cyc;
    cyc = 0;
    while (lanes.size() < n && cyc < 400) begin
      tick();
      cyc++;
    end
    repeat (4) tick();
  endtask

  function automatic logic [63:0] dataWord(input int k, input logic [63:0] unit);
    return unit * 64'(k + 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.pushout !== 1'b0) begin errors++; $display("[TB] FAIL reset_pushout: got %b want 0", bus.pushout); end
    checks++; if (bus.firstout !== 1'b0) begin errors++; $display("[TB] FAIL reset_firstout: got %b want 0", bus.firstout); end
    checks++; if (bus.dout !== 64'd0) begin errors++; $display("[TB] FAIL reset_dout: got %h want 0", bus.dout); end
    checks++; if (bus.stopin !== 1'b0) begin errors++; $display("[TB] FAIL reset_stopin: got %b want 0", bus.stopin); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty();
    logic [63:0] exp;
    lanes.delete(); firsts.delete();
    sendWord(64'd0, 1'b1, 1'b1, 4'd0);
    checks++; if (bus.dout !== 64'h6 || bus.pushout !== 1'b1 || bus.firstout !== 1'b1) begin
      errors++; $display("[TB] FAIL empty_latency: dout=%h push=%b first=%b want 6/1/1", bus.dout, bus.pushout, bus.firstout);
    end
    waitLanes(25);
    checks++; if (lanes.size() !== 25) begin errors++; $display("[TB] FAIL empty_count: got %0d want 25", lanes.size()); end
    for (int k = 0; k < lanes.size() && k < 25; k++) begin
      exp = (k == 0) ? 64'h6 : (k == 16) ? 64'h8000000000000000 : 64'h0;
      checks++; if (lanes[k] !== exp) begin errors++; $display("[TB] FAIL empty_lane%0d: got %h want %h", k, lanes[k], exp); end
      checks++; if (firsts[k] !== (k == 0)) begin errors++; $display("[TB] FAIL empty_first%0d: got %b want %b", k, firsts[k], (k == 0)); end
    end
  endtask

  task automatic test_135_bytes();
    logic [63:0] exp;
    lanes.delete(); firsts.delete();
    for (int k = 0; k < 16; k++) sendWord(dataWord(k, 64'h0101010101010101), (k == 0), 1'b0, 4'd0);
    sendWord(64'hFFEEDDCCBBAA9988, 1'b0, 1'b1, 4'd7);
    waitLanes(25);
    checks++; if (lanes.size() !== 25) begin errors++; $display("[TB] FAIL m135_count: got %0d want 25", lanes.size()); end
    for (int k = 0; k < lanes.size() && k < 25; k++) begin
      exp = (k < 16) ? dataWord(k, 64'h0101010101010101) : (k == 16) ? 64'h86EEDDCCBBAA9988 : 64'h0;
      checks++; if (lanes[k] !== exp) begin errors++; $display("[TB] FAIL m135_lane%0d: got %h want %h", k, lanes[k], exp); end
    end
  endtask

  task automatic test_136_bytes();
    logic [63:0] exp;
    lanes.delete(); firsts.delete();
    for (int k = 0; k < 17; k++) sendWord(dataWord(k, 64'h0101010101010101), (k == 0), (k == 16), 4'd8);
    waitLanes(50);
    checks++; if (lanes.size() !== 50) begin errors++; $display("[TB] FAIL m136_count: got %0d want 50", lanes.size()); end
    for (int k = 0; k < lanes.size() && k < 50; k++) begin
      exp = (k < 17) ? dataWord(k, 64'h0101010101010101) :
            (k == 25) ? 64'h6 : (k == 41) ? 64'h8000000000000000 : 64'h0;
      checks++; if (lanes[k] !== exp) begin errors++; $display("[TB] FAIL m136_lane%0d: got %h want %h", k, lanes[k], exp); end
      checks++; if (firsts[k] !== (k == 0 || k == 25)) begin
        errors++; $display("[TB] FAIL m136_first%0d: got %b want %b", k, firsts[k], (k == 0 || k == 25));
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    lanes.delete(); firsts.delete();
    for (int k = 0; k < 6; k++) sendWord(dataWord(k, 64'h1111111111111111), (k == 0), 1'b0, 4'd0);
    bus.stopout = 1'b1;
    bus.pushin  = 1'b1;
    bus.din     = 64'h7777777777777777;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (bus.dout !== 64'h6666666666666666) begin errors++; $display("[TB] FAIL stall_dout%0d: got %h want 6666666666666666", c, bus.dout); end
      checks++; if (bus.pushout !== 1'b1) begin errors++; $display("[TB] FAIL stall_pushout%0d: got %b want 1", c, bus.pushout); end
      checks++; if (bus.stopin !== 1'b1) begin errors++; $display("[TB] FAIL stall_stopin%0d: got %b want 1", c, bus.stopin); end
    end
    bus.stopout = 1'b0;
    sendWord(64'h7777777777777777, 1'b0, 1'b0, 4'd0);
    sendWord(64'h8888888888888888, 1'b0, 1'b1, 4'd4);
    waitLanes(25);
    checks++; if (lanes.size() !== 25) begin errors++; $display("[TB] FAIL stall_count: got %0d want 25", lanes.size()); end
    for (int k = 0; k < lanes.size() && k < 25; k++) begin
      exp = (k < 7) ? dataWord(k, 64'h1111111111111111) : (k == 7) ? 64'h0000000688888888 :
            (k == 16) ? 64'h8000000000000000 : 64'h0;
      checks++; if (lanes[k] !== exp) begin errors++; $display("[TB] FAIL stall_lane%0d: got %h want %h", k, lanes[k], exp); end
    end
  endtask

  task automatic test_reset_mid();
    lanes.delete(); firsts.delete();
    for (int k = 0; k < 11; k++) sendWord(dataWord(k, 64'h0101010101010101), (k == 0), 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    checks++; if (bus.pushout !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pushout: got %b want 0", bus.pushout); end
    checks++; if (bus.dout !== 64'd0) begin errors++; $display("[TB] FAIL rstmid_dout: got %h want 0", bus.dout); end
    checks++; if (bus.stopin !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stopin: got %b want 0", bus.stopin); end
    rst = 1'b0;
    lanes.delete(); firsts.delete();
    tick();
    sendWord(64'h0000000000636261, 1'b1, 1'b1, 4'd3);
    checks++; if (bus.dout !== 64'h0000000006636261 || bus.firstout !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_restart: dout=%h first=%b want 0000000006636261/1", bus.dout, bus.firstout);
    end
    waitLanes(25);
    checks++; if (lanes.size() !== 25) begin errors++; $display("[TB] FAIL rstmid_count: got %0d want 25", lanes.size()); end
    if (lanes.size() >= 17) begin
      checks++; if (lanes[16] !== 64'h8000000000000000) begin errors++; $display("[TB] FAIL rstmid_lane16: got %h want 8000000000000000", lanes[16]); end
      checks++; if (firsts[0] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_first0: got %b want 1", firsts[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    lanes.delete(); firsts.delete();
    sendWord(64'hDEADBEEFDEADBEEF, 1'b0, 1'b1, 4'd5);
    repeat (3) tick();
    checks++; if (bus.pushout !== 1'b0) begin errors++; $display("[TB] FAIL discard_pushout: got %b want 0", bus.pushout); end
    checks++; if (lanes.size() !== 0) begin errors++; $display("[TB] FAIL discard_count: got %0d want 0", lanes.size()); end
    sendWord(64'd0, 1'b1, 1'b1, 4'd0);
    sendWord(64'h0000000000636261, 1'b1, 1'b1, 4'd3);
    waitLanes(50);
    checks++; if (lanes.size() !== 50) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 50", lanes.size()); end
    for (int k = 0; k < lanes.size() && k < 50; k++) begin
      exp = (k == 0) ? 64'h6 : (k == 25) ? 64'h0000000006636261 :
            (k == 16 || k == 41) ? 64'h8000000000000000 : 64'h0;
      checks++; if (lanes[k] !== exp) begin errors++; $display("[TB] FAIL b2b_lane%0d: got %h want %h", k, lanes[k], exp); end
      checks++; if (firsts[k] !== (k == 0 || k == 25)) begin
        errors++; $display("[TB] FAIL b2b_first%0d: got %b want %b", k, firsts[k], (k == 0 || k == 25));
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
    bus.lastin  = 1'b0;
    bus.nbytes  = 4'd0;
    bus.din     = 64'd0;
    bus.stopout = 1'b0;
    test_reset();
    test_empty();
    test_135_bytes();
    test_136_bytes();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pad_blk.md
PAD_BLK -- requirements
Module: pad_blk

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high; sampled only on rising clk.
REQ-003 SHALL have port pushin  input  1  upstream word valid.
REQ-004 SHALL have port stopin  output  1  backpressure to upstream; a word transfers when pushin && !stopin.
REQ-005 SHALL have port firstin  input  1  marks first word of a message.
REQ-006 SHALL have port lastin  input  1  marks final word of a message.
REQ-007 SHALL have port nbytes  input  4  valid bytes in the lastin word, 0..8; ignored when lastin=0 (word treated as 8 bytes).
REQ-008 SHALL have port din  input  64  message word, little-endian; byte i at din[8i+7:8i].
REQ-009 SHALL have port pushout  output  1  lane valid to perm_blk.
REQ-010 SHALL have port stopout  input  1  downstream backpressure; a lane transfers when pushout && !stopout.
REQ-011 SHALL have port firstout  output  1  high with lane 0 of every block.
REQ-012 SHALL have port dout  output  64  Keccak lane; lanes emitted k=0..24, k=5y+x (x fastest).

Function
REQ-013 SHALL implement SHA3-256 padding: rate 17 lanes (136 B), capacity 8 lanes; every block is exactly 25 lanes, lanes 17..24 all-zero.
REQ-014 SHALL run states IDLE, ABSORB, PADFILL, CAP.
REQ-015 IDLE: stopin=0; a transferred word with firstin=1 becomes lane 0 and enters ABSORB (or PADFILL/CAP if lastin); a word with firstin=0 is discarded.
REQ-016 ABSORB: each transferred word becomes the next rate lane; lane counter 0..16; after lane 16 without lastin -> CAP, then back to ABSORB for next block (firstout on its lane 0).
REQ-017 On lastin with nbytes=n<8: bytes n..7 zeroed, byte n = 0x06; if lane=16 bit 63 additionally set (n=7 gives byte7=0x86).
REQ-018 On lastin with n=8: lane passed unchanged; 0x06 goes to byte 0 of the next rate lane, which may begin a new block if current lane was 16.
REQ-019 PADFILL: emits remaining rate lanes as zero, pending 0x06 in byte 0 where required, lane 16 with bit 63 set; then -> CAP.
REQ-020 CAP: emits 8 zero lanes; after lane 24 -> IDLE (end of message) or ABSORB (continuation).
REQ-021 Output SHALL be a single registered stage: accepted word appears on dout the cycle after transfer (latency 1).
REQ-022 dout/pushout/firstout SHALL hold stable while pushout && stopout.
REQ-023 stopin SHALL be 1 in PADFILL and CAP, and whenever pushout && stopout; otherwise 0.
REQ-024 firstout SHALL be 1 only on lane 0 of each block, never on continuation lanes.
REQ-025 pushin SHALL be ignored while stopin=1; no word lost or duplicated.

Reset
REQ-026 rst=1 at a clk edge SHALL force IDLE, lane counter 0, pad-pending clear, pushout=0, firstout=0, dout=0, stopin=0, regardless of state.
REQ-027 Reset mid-block SHALL abandon the block; next emitted lane after release is lane 0 with firstout=1.

Structure
REQ-028 Shared package SHALL hold RATE_LANES=17, NUM_LANES=25, PAD_DOMAIN=8'h06, PAD_END=8'h80 and the state enum.
REQ-029 Byte masking/pad insertion SHALL be a combinational sub-module pad_lane (inputs din, nbytes, lastin, lane index, pad-pending; output padded lane).

Verification
REQ-030 Empty message (firstin,lastin,nbytes=0) -> 25 lanes: lane0=0x0000000000000006, lane16=0x8000000000000000, rest 0, firstout lane0 only.
REQ-031 "abc" din=0x0000000000636261 nbytes=3 -> lane0=0x0000000006636261, lane16=0x8000000000000000.
REQ-032 135-byte message (17th word nbytes=7) -> lane16 byte7=0x86, exactly 25 lanes.
REQ-033 136-byte message -> 50 lanes; block2 lane0=0x06, lane16=0x8000000000000000, firstout on lanes 0 and 25.
REQ-034 stopout held 10 cycles at lane 5 -> dout stable, stopin=1, pushin words not consumed, stream resumes intact.
REQ-035 rst pulsed at lane 10 -> pushout=0 next cycle; new message restarts at lane 0 with firstout=1.
